// File: rtl/sam_pkg.sv
// Shared definitions for the microcoded machine: memory sequencer state
// encoding, default datapath widths and control-word strobe positions.
package sam_pkg;

    localparam int SAM_ADDR_W = 12;
    localparam int SAM_DATA_W = 16;

    // Bit positions of the memory strobes inside the control-ROM word.
    localparam int CW_MEM_RD_BIT = 20;
    localparam int CW_MEM_WR_BIT = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_interface.sv
// Memory access sequencer: turns controller read/write strobes into a
// req/ack memory transaction, holds the controller via wait_, flags timeouts.
module mem_interface
    import sam_pkg::*;
#(
    parameter int ADDR_W   = SAM_ADDR_W,
    parameter int DATA_W   = SAM_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [DATA_W-1:0] mbr_wdata,
    output logic              wait_,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mem_state_e        r_state;
    logic [7:0]        r_cnt;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              r_timeout;

    logic w_strobe;
    logic w_last;

    assign w_strobe = mem_rd | mem_wr;
    // Counter holds the number of ack-less REQ cycles already completed, so
    // this edge closes the MAX_WAIT-th one.
    assign w_last   = (r_cnt == 8'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_strobe) begin
                        r_addr  <= mar_addr;
                        r_wdata <= mbr_wdata;
                        r_we    <= mem_wr;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata       <= mem_rdata;
                            r_rdata_valid <= 1'b1;
                        end
                        r_req   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_last) begin
                        if (!r_we) r_rdata <= '1;
                        r_timeout <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wait_       = (r_state == REQ) || ((r_state == IDLE) && w_strobe);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign timeout_err = r_timeout;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: directed table, corner sequences
// and randomized accesses against a transaction-level model.
module tb_mem_interface;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mar_addr;
    logic [DATA_W-1:0] mbr_wdata;
    logic              wait_;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid, timeout_err;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    int checks   = 0;
    int failures = 0;

    mem_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mar_addr(mar_addr), .mbr_wdata(mbr_wdata), .wait_(wait_),
        .rdata(rdata), .rdata_valid(rdata_valid), .timeout_err(timeout_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rd, wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                ack_at;   // REQ cycle carrying the ack; 0 = never
        logic [DATA_W-1:0] mrd;
        logic              exp_we;
        int                exp_reqs;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_valid;
        logic              exp_tout;
    } vec_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                reqs;
        int                wait_cycles;
        int                unstable;
        int                valid_end;
        int                valid_total;
        logic              wait_end;
        logic [DATA_W-1:0] rdata_end;
        logic              tout_end;
    } obs_t;

    logic [DATA_W-1:0] m_rdata;
    logic              m_tout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one strobe cycle, plays memory with an ack on REQ cycle ack_at,
    // and records what the sequencer did until it returns to IDLE.
    task automatic run_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input int ack_at,
                              input logic [DATA_W-1:0] mrd, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; mar_addr = addr; mbr_wdata = wd;
        #1;
        if (wait_) o.wait_cycles++;
        o.valid_total += int'(rdata_valid);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        mar_addr = ~addr; mbr_wdata = ~wd;
        for (int c = 1; c <= 300; c++) begin
            if (!mem_req) break;
            if (c == 300) begin
                failures++;
                $display("FAIL req_bound: mem_req still high after %0d cycles", c);
                break;
            end
            o.reqs++;
            if (c == 1) begin
                o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
            end else if (mem_we !== o.we || mem_addr !== o.addr || mem_wdata !== o.wdata) begin
                o.unstable++;
            end
            if (wait_) o.wait_cycles++;
            o.valid_total += int'(rdata_valid);
            mem_ack = (c == ack_at); mem_rdata = mrd;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        o.valid_end   = int'(rdata_valid);
        o.valid_total += int'(rdata_valid);
        o.wait_end    = wait_;
        o.rdata_end   = rdata;
        o.tout_end    = timeout_err;
        @(negedge clk);
        o.valid_total += int'(rdata_valid);
    endtask

    // Transaction-level reference: outcome follows from when (or whether)
    // the ack arrives within the MAX_WAIT window.
    task automatic model(input logic rd, input logic wr, input int ack_at,
                         input logic [DATA_W-1:0] mrd, output vec_t e);
        bit acked;
        acked = (ack_at >= 1) && (ack_at <= MAX_WAIT);
        e.exp_we    = wr;
        e.exp_reqs  = acked ? ack_at : MAX_WAIT;
        e.exp_valid = (acked && !wr) ? 1 : 0;
        if (!wr) m_rdata = acked ? mrd : '1;
        if (!acked) m_tout = 1'b1;
        e.exp_rdata = m_rdata;
        e.exp_tout  = m_tout;
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o);
        chk({tag, "_we"},     32'(o.we), 32'(v.exp_we));
        chk({tag, "_addr"},   32'(o.addr), 32'(v.addr));
        chk({tag, "_wdata"},  32'(o.wdata), 32'(v.wdata));
        chk({tag, "_stable"}, 32'(o.unstable), 32'd0);
        chk({tag, "_reqs"},   32'(o.reqs), 32'(v.exp_reqs));
        chk({tag, "_wait"},   32'(o.wait_cycles), 32'(v.exp_reqs + 1));
        chk({tag, "_waitend"}, 32'(o.wait_end), 32'd0);
        chk({tag, "_vend"},   32'(o.valid_end), 32'(v.exp_valid));
        chk({tag, "_vtot"},   32'(o.valid_total), 32'(v.exp_valid));
        chk({tag, "_rdata"},  32'(o.rdata_end), 32'(v.exp_rdata));
        chk({tag, "_tout"},   32'(o.tout_end), 32'(v.exp_tout));
    endtask

    vec_t tbl[7];

    initial begin
        obs_t o;
        vec_t e;

        tbl[0] = '{1, 0, 12'h0A5, 16'h0000, 3,  16'h1234, 0, 3,  16'h1234, 1, 0};
        tbl[1] = '{0, 1, 12'hFFF, 16'hBEEF, 1,  16'h5555, 1, 1,  16'h1234, 0, 0};
        tbl[2] = '{1, 1, 12'h123, 16'hCAFE, 2,  16'h7777, 1, 2,  16'h1234, 0, 0};
        tbl[3] = '{1, 0, 12'h200, 16'h0002, 15, 16'hA5A5, 0, 15, 16'hA5A5, 1, 0};
        tbl[4] = '{1, 0, 12'h300, 16'h0003, 0,  16'h4321, 0, 15, 16'hFFFF, 0, 1};
        tbl[5] = '{1, 0, 12'h301, 16'h0004, 2,  16'h0F0F, 0, 2,  16'h0F0F, 1, 1};
        tbl[6] = '{0, 1, 12'h302, 16'h0005, 0,  16'h0000, 1, 15, 16'h0F0F, 0, 1};

        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mar_addr = '0; mbr_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_wait",  32'(wait_), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_valid", 32'(rdata_valid), 32'd0);
        chk("rst_tout",  32'(timeout_err), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        mem_rd = 1'b1; #1;
        chk("rst_wait_strobe", 32'(wait_), 32'd1);
        mem_rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Spurious ack while idle must not start anything.
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk); mem_ack = 1'b0;
        chk("spur_req",   32'(mem_req), 32'd0);
        chk("spur_valid", 32'(rdata_valid), 32'd0);
        chk("spur_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        chk("spur_req2",  32'(mem_req), 32'd0);
        chk("spur_wait",  32'(wait_), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ack_at, tbl[i].mrd, o);
            compare($sformatf("tbl%0d", i), tbl[i], o);
        end

        // New strobes during REQ are ignored.
        @(negedge clk); mem_rd = 1'b1; mar_addr = 12'h0AA; mbr_wdata = 16'h0001;
        @(negedge clk); mem_wr = 1'b1; mar_addr = 12'h555; mbr_wdata = 16'h9999;
        @(negedge clk);
        chk("restrobe_req",   32'(mem_req), 32'd1);
        chk("restrobe_addr",  32'(mem_addr), 32'h0AA);
        chk("restrobe_we",    32'(mem_we), 32'd0);
        chk("restrobe_wdata", 32'(mem_wdata), 32'h0001);
        mem_ack = 1'b1; mem_rdata = 16'h4444; mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk); mem_ack = 1'b0;
        chk("restrobe_rdata", 32'(rdata), 32'h4444);
        chk("restrobe_valid", 32'(rdata_valid), 32'd1);
        chk("restrobe_wait",  32'(wait_), 32'd0);
        @(negedge clk);
        chk("restrobe_idle_req",   32'(mem_req), 32'd0);
        chk("restrobe_idle_valid", 32'(rdata_valid), 32'd0);

        // Asynchronous reset in the middle of a request.
        @(negedge clk); mem_wr = 1'b1; mar_addr = 12'h3C3; mbr_wdata = 16'h1111;
        @(negedge clk); mem_wr = 1'b0;
        @(negedge clk);
        chk("midrst_pre_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req",   32'(mem_req), 32'd0);
        chk("midrst_wait",  32'(wait_), 32'd0);
        chk("midrst_addr",  32'(mem_addr), 32'd0);
        chk("midrst_we",    32'(mem_we), 32'd0);
        chk("midrst_wdata", 32'(mem_wdata), 32'd0);
        chk("midrst_tout",  32'(timeout_err), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        m_rdata = '0; m_tout = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            vec_t v;
            kind = $urandom_range(1, 3);
            v.rd     = kind[0];
            v.wr     = kind[1];
            v.addr   = ADDR_W'($urandom);
            v.wdata  = DATA_W'($urandom);
            v.ack_at = (n == 7) ? 0 : int'($urandom_range(0, MAX_WAIT + 2));
            v.mrd    = DATA_W'($urandom);
            model(v.rd, v.wr, v.ack_at, v.mrd, e);
            v.exp_we = e.exp_we; v.exp_reqs = e.exp_reqs; v.exp_rdata = e.exp_rdata;
            v.exp_valid = e.exp_valid; v.exp_tout = e.exp_tout;
            run_access(v.rd, v.wr, v.addr, v.wdata, v.ack_at, v.mrd, o);
            compare($sformatf("rnd%0d", n), v, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory access sequencer between the microcoded controller/datapath and the external word memory.
- Takes the read and write strobes that the top level decodes from bus_controller, plus the MAR address and the MBR write data.
- Runs a req/ack handshake with memory and drives wait_ back to the controller, which loops on it through its alpha/beta branch mux.
- Returns read data for the MBR load and flags memory timeouts.

Parameters:
- ADDR_W, 12, memory address width (MAR width).
- DATA_W, 16, data word width (AC/MBR width).
- MAX_WAIT, 15, number of REQ cycles without mem_ack before timeout; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd  in  1  read strobe from the control word.
- mem_wr  in  1  write strobe from the control word.
- mar_addr  in  ADDR_W  address from MAR.
- mbr_wdata  in  DATA_W  write data from MBR.
- wait_  out  1  1 = access in progress; controller must hold.
- rdata  out  DATA_W  last read word, for the MBR load.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- timeout_err  out  1  sticky timeout flag.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, single cycle.

Behaviour:
- Reset (asynchronous, active while rst_n=0):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata=0, rdata_valid=0, timeout_err=0, wait counter=0.
  - wait_ follows the combinational rule below, so it is 0 when no strobe is present.
  - Reset in the middle of an access aborts it; mem_req drops immediately, without waiting for a clock edge.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - If mem_rd or mem_wr is high at a clock edge: latch mar_addr into mem_addr and mbr_wdata into mem_wdata; set mem_we=mem_wr; clear the counter; go to REQ.
  - If mem_rd and mem_wr are both high, the access is a write.
  - mem_ack in IDLE is ignored.
- REQ:
  - mem_req=1; mem_addr, mem_we and mem_wdata stay stable.
  - If mem_ack is high at a clock edge: for a read, capture mem_rdata into rdata; go to DONE.
  - Otherwise the counter increments. At the edge where the counter reaches MAX_WAIT-1 with no ack, go to ERR.
  - mem_ack arriving on that same final edge wins: go to DONE, not ERR.
- DONE:
  - mem_req=0.
  - rdata_valid=1 for this single cycle, on reads only.
  - Go to IDLE.
- ERR:
  - mem_req=0; set timeout_err (sticky until reset).
  - For a read, rdata is loaded with all ones.
  - Go to IDLE.
- wait_ (combinational) = (state==REQ) or (state==IDLE and (mem_rd or mem_wr)).
  - This makes wait_ high in the same cycle the strobe appears, so the microinstruction issuing the access can branch on it immediately.
  - wait_=0 in DONE and ERR, so the controller is never hung by a timeout.
- Strobes while in REQ, DONE or ERR are ignored. No queuing; the controller re-issues the access if needed.
- Latency:
  - Strobe sampled at edge 0; mem_req is high from edge 1.
  - Ack sampled at edge k; DONE (wait_=0, rdata valid) holds in cycle k..k+1.
  - Minimum access is 3 cycles from strobe to IDLE.
- Counter is 8 bits wide.
- All outputs are registered except wait_.

Decomposition:
- Shared package sam_pkg: state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2, ERR=2'd3) and the default widths ADDR_W and DATA_W. The controller/ROM bit positions for mem_rd and mem_wr belong in sam_pkg as well.
- Sub-module: none required. The wait counter may optionally be split out as wait_counter (clear, enable, terminal-count output).

Test Plan:
- Read, ack after 2 REQ cycles:
  - Stimulus: mem_rd=1, mar_addr=12'h0A5; memory acks with mem_rdata=16'h1234.
  - Response: wait_=1 for the strobe cycle plus 3 REQ cycles; mem_we=0; mem_addr=12'h0A5; then rdata=16'h1234 with a single rdata_valid pulse; wait_=0 afterwards.
- Write, immediate ack:
  - Stimulus: mem_wr=1, mar_addr=12'hFFF, mbr_wdata=16'hBEEF; ack on the first REQ cycle.
  - Response: mem_we=1; mem_wdata=16'hBEEF; no rdata_valid pulse; rdata unchanged.
- Timeout:
  - Stimulus: read with MAX_WAIT=15 and no ack.
  - Response: exactly 15 REQ cycles, then ERR; timeout_err=1 (sticky); rdata=16'hFFFF; wait_ returns to 0. The next read with an ack completes normally while timeout_err stays 1.
- Simultaneous strobes and re-strobe:
  - Stimulus: mem_rd=mem_wr=1; in a second test, a new strobe during REQ.
  - Response: the access is a write; the strobe during REQ is ignored and mem_addr is unchanged.
- Ack on the boundary:
  - Stimulus: ack on the MAX_WAIT-th REQ cycle.
  - Response: DONE is taken; no timeout_err.
- Reset mid-REQ:
  - Stimulus: deassert rst_n between edges.
  - Response: mem_req, wait_ and all other outputs go to their reset values immediately, without waiting for a clock edge.
- Spurious ack:
  - Stimulus: mem_ack pulse while in IDLE.
  - Response: no state change.
